// File: rtl/n_deserial.sv
// Serial-to-parallel receiver for SD CMD/DAT lines: waits for a start bit, shifts in an
// n-bit MSB-first frame, and reports completion, end-bit error and start-bit timeout.
module n_deserial #(
  parameter int n       = 48,
  parameter int TIMEOUT = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         serial,
  output logic [n-1:0] parallel,
  output logic         complete,
  output logic         frame_error,
  output logic         timeout,
  output logic         busy
);

  localparam int BC_W = $clog2(n) + 1;
  localparam int TC_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE} state_t;

  state_t          state_q, state_d;
  logic [n-1:0]    shreg_q, shreg_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic [TC_W-1:0] tcnt_q, tcnt_d;
  logic [n-1:0]    par_q, par_d;
  logic            cmp_q, cmp_d;
  logic            ferr_q, ferr_d;
  logic            to_q, to_d;
  logic            busy_q, busy_d;

  assign parallel    = par_q;
  assign complete    = cmp_q;
  assign frame_error = ferr_q;
  assign timeout     = to_q;
  assign busy        = busy_q;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    tcnt_d  = tcnt_q;
    par_d   = par_q;
    cmp_d   = 1'b0;
    ferr_d  = ferr_q;
    to_d    = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_START;
          busy_d  = 1'b1;
          tcnt_d  = '0;
        end
      end
      WAIT_START: begin
        // A start bit wins over timeout, even on the final allowed sample.
        if (!serial) begin
          shreg_d = {{(n-1){1'b0}}, serial};
          bcnt_d  = BC_W'(1);
          state_d = RECEIVE;
        end else if (tcnt_q == TC_W'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + TC_W'(1);
        end
      end
      RECEIVE: begin
        shreg_d = {shreg_q[n-2:0], serial};
        bcnt_d  = bcnt_q + BC_W'(1);
        if (bcnt_q == BC_W'(n - 1)) begin
          par_d   = {shreg_q[n-2:0], serial};
          cmp_d   = 1'b1;
          ferr_d  = ~serial;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      par_q   <= '0;
      cmp_q   <= 1'b0;
      ferr_q  <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      par_q   <= par_d;
      cmp_q   <= cmp_d;
      ferr_q  <= ferr_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end

endmodule
